// File: rtl/serial_operand_sender.sv
// Streams two N-bit operands MSB first on x/y after a one-cycle comparator clear.
// Optional macro RESULT_CAPTURE_EN adds capture of the comparator's gt/lt result.
module serial_operand_sender #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         start_valid,
`ifdef RESULT_CAPTURE_EN
  input  logic         gt_in,
  input  logic         lt_in,
  output logic         res_gt,
  output logic         res_lt,
  output logic         res_valid,
`endif
  output logic         start_ready,
  output logic         x,
  output logic         y,
  output logic         cmp_reset,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW = $clog2(N) + 1;

  // state   | meaning
  // S_IDLE  | waiting for a start handshake
  // S_CLEAR | one cycle of cmp_reset before the first bit
  // S_SHIFT | N cycles, one operand bit pair per cycle
  // S_DONE  | one cycle frame_done pulse
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  sa_q, sb_q;
  logic [CW-1:0] cnt_q;
  logic          x_q, y_q, rdy_q, busy_q, cmpr_q, fd_q;
`ifdef RESULT_CAPTURE_EN
  logic          res_gt_q, res_lt_q, res_valid_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      cmpr_q  <= 1'b1;
      fd_q    <= 1'b0;
`ifdef RESULT_CAPTURE_EN
      res_gt_q    <= 1'b0;
      res_lt_q    <= 1'b0;
      res_valid_q <= 1'b0;
`endif
    end else begin
      cmpr_q <= 1'b0;
      fd_q   <= 1'b0;
      x_q    <= 1'b0;
      y_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
          if (start_valid && rdy_q) begin
            sa_q    <= a;
            sb_q    <= b;
            state_q <= S_CLEAR;
            cmpr_q  <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef RESULT_CAPTURE_EN
            res_gt_q    <= 1'b0;
            res_lt_q    <= 1'b0;
            res_valid_q <= 1'b0;
`endif
          end
        end
        S_CLEAR: begin
          x_q     <= sa_q[N-1];
          y_q     <= sb_q[N-1];
          sa_q    <= {sa_q[N-2:0], 1'b0};
          sb_q    <= {sb_q[N-2:0], 1'b0};
          cnt_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // cnt_q counts bits already presented; the last bit moves us to DONE
          if (cnt_q == CW'(N - 1)) begin
            state_q <= S_DONE;
            fd_q    <= 1'b1;
          end else begin
            x_q   <= sa_q[N-1];
            y_q   <= sb_q[N-1];
            sa_q  <= {sa_q[N-2:0], 1'b0};
            sb_q  <= {sb_q[N-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
`ifdef RESULT_CAPTURE_EN
          res_gt_q    <= gt_in;
          res_lt_q    <= lt_in;
          res_valid_q <= 1'b1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready = rdy_q;
  assign x           = x_q;
  assign y           = y_q;
  assign cmp_reset   = cmpr_q;
  assign busy        = busy_q;
  assign frame_done  = fd_q;
`ifdef RESULT_CAPTURE_EN
  assign res_gt      = res_gt_q;
  assign res_lt      = res_lt_q;
  assign res_valid   = res_valid_q;
`endif

endmodule

// File: tb/tb_serial_operand_sender.sv
// Scoreboarded random bench for serial_operand_sender (N=4) plus a directed N=8 frame.
module tb_serial_operand_sender;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [N-1:0] a = '0, b = '0;
  logic         start_valid = 1'b0;
  logic         start_ready, x, y, cmp_reset, busy, frame_done;
`ifdef RESULT_CAPTURE_EN
  logic gt_in = 1'b0, lt_in = 1'b0;
  logic res_gt, res_lt, res_valid;
  logic res_gt8, res_lt8, res_valid8;
`endif

  logic       reset8 = 1'b1, sv8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       rdy8, x8, y8, cmpr8, busy8, fd8;

  serial_operand_sender #(.N(N)) u_dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .start_valid(start_valid),
`ifdef RESULT_CAPTURE_EN
    .gt_in(gt_in), .lt_in(lt_in), .res_gt(res_gt), .res_lt(res_lt), .res_valid(res_valid),
`endif
    .start_ready(start_ready), .x(x), .y(y), .cmp_reset(cmp_reset),
    .busy(busy), .frame_done(frame_done)
  );

  serial_operand_sender #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset8), .a(a8), .b(b8), .start_valid(sv8),
`ifdef RESULT_CAPTURE_EN
    .gt_in(1'b0), .lt_in(1'b0), .res_gt(res_gt8), .res_lt(res_lt8), .res_valid(res_valid8),
`endif
    .start_ready(rdy8), .x(x8), .y(y8), .cmp_reset(cmpr8),
    .busy(busy8), .frame_done(fd8)
  );

  int checks = 0, errors = 0;
  int edge_cnt = 0;
  logic rst_at_edge = 1'b0;

  always @(posedge clk) begin
    edge_cnt    <= edge_cnt + 1;
    rst_at_edge <= reset;
  end

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           t;   // index of the accepting edge
  } frame_t;
  frame_t exp_q[$];
  int last_t = -1000;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s edge %0d: got %b expected %b", name, edge_cnt, act, exp_v);
    end
  endtask

  // Drive inputs for the next edge; the model accepts only when N+3 edges have passed
  task automatic drive(input logic r, input logic sv, input logic [N-1:0] av, input logic [N-1:0] bv);
    int tn;
    frame_t f;
    @(negedge clk);
    reset = r; start_valid = sv; a = av; b = bv;
    tn = edge_cnt + 1;
    if (r) last_t = -1000;
    else if (sv && (tn - last_t >= N + 3)) begin
      f.a = av; f.b = bv; f.t = tn;
      exp_q.push_back(f);
      last_t = tn;
`ifdef RESULT_CAPTURE_EN
      gt_in = (av > bv);
      lt_in = (av < bv);
`endif
    end
  endtask

  // Monitor: expected {start_ready,busy,cmp_reset,frame_done,x,y} each cycle
  logic [5:0] ev;
  int d;
`ifdef RESULT_CAPTURE_EN
  logic er_gt = 0, er_lt = 0, er_valid = 0, cap_pend = 0, cap_gt = 0, cap_lt = 0;
`endif
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
`ifdef RESULT_CAPTURE_EN
      if (cap_pend && !rst_at_edge) begin
        er_gt = cap_gt; er_lt = cap_lt; er_valid = 1'b1;
      end
      cap_pend = 1'b0;
`endif
      if (rst_at_edge) begin
        ev = 6'b101000;
        if (exp_q.size() > 0 && exp_q[0].t <= edge_cnt) void'(exp_q.pop_front());
`ifdef RESULT_CAPTURE_EN
        er_gt = 0; er_lt = 0; er_valid = 0;
`endif
      end else if (exp_q.size() > 0 && edge_cnt >= exp_q[0].t) begin
        d = edge_cnt - exp_q[0].t;
        if (d == 0) begin
          ev = 6'b011000;
`ifdef RESULT_CAPTURE_EN
          er_gt = 0; er_lt = 0; er_valid = 0;
`endif
        end else if (d <= N) begin
          ev = {4'b0100, exp_q[0].a[N-d], exp_q[0].b[N-d]};
        end else begin
          ev = 6'b010100;
`ifdef RESULT_CAPTURE_EN
          cap_pend = 1'b1;
          cap_gt = (exp_q[0].a > exp_q[0].b);
          cap_lt = (exp_q[0].a < exp_q[0].b);
`endif
          void'(exp_q.pop_front());
        end
      end else begin
        ev = 6'b100000;
      end
      check("outputs", {2'b00, start_ready, busy, cmp_reset, frame_done, x, y}, {2'b00, ev});
`ifdef RESULT_CAPTURE_EN
      check("result", {5'b0, res_valid, res_gt, res_lt}, {5'b0, er_valid, er_gt, er_lt});
`endif
    end
  end

  initial begin
    repeat (3) drive(1, 0, '0, '0);
    // directed 1010 / 0110 frame
    drive(0, 1, 4'b1010, 4'b0110);
    repeat (8) drive(0, 0, '0, '0);
    // start_valid pulse with a=F during SHIFT is ignored; a/b wiggle mid-frame
    drive(0, 1, 4'h9, 4'h5);
    drive(0, 0, 4'h0, 4'h0);
    drive(0, 1, 4'hF, 4'hF);
    drive(0, 0, 4'hF, 4'h1);
    repeat (6) drive(0, 0, '0, '0);
    drive(0, 1, 4'h3, 4'h3);
    repeat (8) drive(0, 0, '0, '0);
    // reset during the second SHIFT cycle, then reset coinciding with start_valid
    drive(0, 1, 4'hC, 4'h3);
    drive(0, 0, '0, '0);
    drive(0, 0, '0, '0);
    drive(1, 0, '0, '0);
    drive(0, 0, '0, '0);
    drive(1, 1, 4'hA, 4'hA);
    repeat (3) drive(0, 0, '0, '0);
    // back-to-back frames with start_valid held high
    for (int i = 0; i < 30; i++) drive(0, 1, N'($urandom), N'($urandom));
    // random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 50), N'($urandom), N'($urandom));
    repeat (10) drive(0, 0, '0, '0);

    // N=8 directed frame: x only in SHIFT cycle 0, y only in SHIFT cycle 7
    @(negedge clk); reset8 = 1'b0; sv8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    @(negedge clk); sv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    check("n8_clear", {4'b0, rdy8, busy8, cmpr8, fd8}, 8'b0000_0110);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("n8_shift", {5'b0, fd8, x8, y8}, {5'b0, 1'b0, (k == 0), (k == 7)});
    end
    @(negedge clk);
    check("n8_done", {4'b0, busy8, fd8, x8, y8}, 8'b0000_1100);
    @(negedge clk);
    check("n8_idle", {6'b0, rdy8, busy8}, 8'b0000_0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_operand_sender.md
SERIAL_OPERAND_SENDER -- requirements
Module: serial_operand_sender

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port a, input, N, operand streamed on x.
REQ-005 The block SHALL have port b, input, N, operand streamed on y.
REQ-006 The block SHALL have port start_valid, input, 1, request to send a/b.
REQ-007 The block SHALL have port start_ready, output, 1, high only in IDLE.
REQ-008 The block SHALL have port x, output, 1, serial bit of a, MSB first.
REQ-009 The block SHALL have port y, output, 1, serial bit of b, MSB first.
REQ-010 The block SHALL have port cmp_reset, output, 1, clear pulse for the downstream serial comparator.
REQ-011 The block SHALL have port busy, output, 1, high in CLEAR, SHIFT and DONE.
REQ-012 The block SHALL have port frame_done, output, 1, one-cycle pulse in DONE.

Function
REQ-013 FSM states SHALL be IDLE, CLEAR, SHIFT, DONE; all outputs SHALL be registered.
REQ-014 Handshake: transfer occurs on a rising edge with start_valid=1 and start_ready=1; a and b SHALL be latched into internal shift registers on that edge.
REQ-015 start_valid while start_ready=0 SHALL be ignored, with no queuing.
REQ-016 IDLE -> CLEAR on transfer; CLEAR lasts exactly 1 cycle with cmp_reset=1, x=0, y=0.
REQ-017 CLEAR -> SHIFT; SHIFT lasts exactly N cycles.
REQ-018 In SHIFT cycle k (k=0..N-1), x SHALL equal a[N-1-k] and y SHALL equal b[N-1-k].
REQ-019 The bit counter SHALL be ceil(log2(N))+1 bits wide and SHALL not wrap within a frame.
REQ-020 SHIFT -> DONE after bit N-1; DONE lasts 1 cycle with frame_done=1, x=0, y=0.
REQ-021 DONE -> IDLE unconditionally; start_ready SHALL return to 1 in the cycle after DONE.
REQ-022 Total latency from the accepting edge to the frame_done cycle SHALL be N+1 cycles; frame period SHALL be N+3 cycles minimum.
REQ-023 cmp_reset SHALL be 0 outside CLEAR, except while reset is asserted (see REQ-025).
REQ-024 Changes on a/b after transfer SHALL not affect the frame in progress.

Reset
REQ-025 While reset=1 on a clock edge: state=IDLE, x=0, y=0, busy=0, frame_done=0, start_ready=1, cmp_reset=1, and all internal registers cleared.
REQ-026 Reset mid-frame SHALL abort the frame with no frame_done; a start_valid coinciding with reset SHALL be dropped.
REQ-027 In the first cycle after reset deasserts, cmp_reset SHALL be 0 and start_ready SHALL be 1.

Configuration
REQ-028 Macro RESULT_CAPTURE_EN SHALL add inputs gt_in and lt_in (1 bit each, from the comparator) and outputs res_gt, res_lt and res_valid (1 bit each).
REQ-029 With RESULT_CAPTURE_EN defined: gt_in/lt_in SHALL be sampled on the edge that ends DONE into res_gt/res_lt, with res_valid=1 from the next cycle and held until the next transfer edge, which clears all three; reset SHALL clear all three.
REQ-030 Without RESULT_CAPTURE_EN: those ports and registers SHALL not exist, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, then start a=4'b1010, b=4'b0110 -> CLEAR with cmp_reset=1; x sequence 1,0,1,0; y sequence 0,1,1,0; frame_done 5 cycles after accept.
REQ-032 Pulse start_valid during SHIFT with a=4'hF -> ignored; the frame bits are unchanged and no second frame is sent.
REQ-033 Assert reset in the 2nd SHIFT cycle -> next cycle IDLE, x=y=0, no frame_done, start_ready=1.
REQ-034 Hold start_valid high continuously -> back-to-back frames at a 7-cycle period (N=4), with start_ready=1 for exactly 1 cycle between frames.
REQ-035 With RESULT_CAPTURE_EN, a=9, b=5 looped through the comparator -> res_gt=1, res_lt=0, res_valid=1; then a=b=3 -> res_gt=0, res_lt=0.
REQ-036 N=8, a=8'h80, b=8'h01 -> x high only in SHIFT cycle 0, y high only in SHIFT cycle 7.
